// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, LSB first, one start and one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CLK_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CLK_CNT_W-1:0] CLK_LAST = CLK_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                r_state;
    state_t                w_next_state;
    logic [CLK_CNT_W-1:0]  r_clk_count;
    logic [BIT_CNT_W-1:0]  r_bit_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  r_tx;
    logic                  r_done;
    logic                  w_tx_next;
    logic                  w_done_next;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic w_accept;
    logic w_bit_end;
    logic w_last_bit;

    assign w_accept   = data_valid && (r_state == S_IDLE);
    assign w_bit_end  = (r_clk_count == CLK_LAST);
    assign w_last_bit = (r_bit_count == BIT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_clk_count <= '0;
            r_bit_count <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
            if (r_state == S_IDLE || w_next_state != r_state) begin
                r_clk_count <= '0;
            end else begin
                r_clk_count <= r_clk_count + 1'b1;
            end
            if (r_state == S_DATA && w_bit_end && !w_last_bit) begin
                r_bit_count <= r_bit_count + 1'b1;
            end else if (r_state != S_DATA || w_bit_end) begin
                r_bit_count <= '0;
            end
`ifdef UART_TX_PARITY_EN
            if (w_accept) begin
                r_parity <= ^data_in;
            end
`endif
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_START;
            S_START:  if (w_bit_end) w_next_state = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (w_bit_end && w_last_bit) w_next_state = S_PARITY;
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
`else
            S_DATA:   if (w_bit_end && w_last_bit) w_next_state = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // tx is registered, so its next value follows the state being entered.
    always_comb begin
        w_shift_next = r_shift;
        if (w_accept) begin
            w_shift_next = data_in;
        end else if (r_state == S_DATA && w_bit_end) begin
            w_shift_next = r_shift >> 1;
        end
        case (w_next_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
        w_done_next = (r_state == S_STOP) && w_bit_end;
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = !ready;
    assign tx    = r_tx;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a bit-list frame model.
module tb_uart_tx;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int DATA_WIDTH = 8;
    localparam int CPB        = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 1 + DATA_WIDTH + 1 + 1;
`else
    localparam int NBITS = 1 + DATA_WIDTH + 1;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_miss = 0;
    int cur_cycle = 0;

    always #5 clock = ~clock;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    // Expected line level c cycles after acceptance: the frame as a list of bits.
    function automatic logic model_tx(input logic [7:0] d, input int c);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_WIDTH; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        return bits[(c - 1) / CPB];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s cycle=%0d: got %0h expected %0h", tag, cur_cycle, obs, exp);
        end
    endtask

    task automatic frame(input logic [7:0] d, input bit chained, input bit hold,
                         input logic [7:0] next_d, input int glitch_c);
        if (!chained) begin
            data_in    = d;
            data_valid = 1'b1;
        end
        cur_cycle = 0;
        check("ready_at_accept", ready, 1);
        @(posedge clock);
        @(negedge clock);
        for (int c = 1; c <= NBITS * CPB; c++) begin
            cur_cycle = c;
            if (hold) begin
                data_valid = 1'b1;
                data_in    = next_d;
            end else if (c == glitch_c) begin
                data_valid = 1'b1;
                data_in    = 8'hFF;
            end else begin
                data_valid = 1'b0;
                data_in    = 8'($urandom);
            end
            check("tx", tx, model_tx(d, c));
            check("ready_busy_frame", ready, 0);
            check("busy_frame", busy, 1);
            check("done_early", done, 0);
            @(negedge clock);
        end
        cur_cycle = NBITS * CPB + 1;
        check("done_pulse", done, 1);
        check("ready_end", ready, 1);
        check("busy_end", busy, 0);
        check("tx_idle", tx, 1);
        if (!hold) begin
            data_valid = 1'b0;
            @(negedge clock);
            cur_cycle++;
            check("done_single", done, 0);
            check("tx_idle2", tx, 1);
        end
    endtask

    initial begin
        logic [7:0] rd;
        repeat (2) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;

        frame(8'h55, 1'b0, 1'b0, 8'h00, 0);

        frame(8'hA5, 1'b0, 1'b1, 8'h3C, 0);
        frame(8'h3C, 1'b1, 1'b0, 8'h00, 0);

        rd = 8'($urandom);
        frame(rd, 1'b0, 1'b0, 8'h00, 40);

        data_in    = 8'h00;
        data_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        data_valid = 1'b0;
        repeat (69) @(negedge clock);
        cur_cycle = 70;
        check("pre_reset_tx", tx, model_tx(8'h00, 70));
        check("pre_reset_ready", ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_ready", ready, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_no_done", done, 0);
        end
        reset_n = 1'b1;
        frame(8'h81, 1'b0, 1'b0, 8'h00, 0);

`ifdef UART_TX_PARITY_EN
        frame(8'h07, 1'b0, 1'b0, 8'h00, 0);
        frame(8'h03, 1'b0, 1'b0, 8'h00, 0);
`endif

        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            frame(rd, 1'b0, 1'b0, 8'h00, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 CLK_FREQ, default 100_000_000, SHALL be the clock frequency in Hz.
REQ-002 BAUD_RATE, default 115200, SHALL be the line bit rate in bits/s.
REQ-003 DATA_WIDTH, default 8, SHALL be the number of data bits per frame.
REQ-004 CLKS_PER_BIT SHALL be a localparam equal to CLK_FREQ / BAUD_RATE (integer division), with a minimum legal value of 2.
REQ-005 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 data_in  input  DATA_WIDTH  SHALL carry the byte to send, sampled only at acceptance.
REQ-008 data_valid  input  1  SHALL indicate that data_in holds a valid byte.
REQ-009 ready  output  1  SHALL be high when a new byte can be accepted.
REQ-010 tx  output  1  SHALL be the registered serial line, with idle level 1.
REQ-011 busy  output  1  SHALL be high while a frame is in progress.
REQ-012 done  output  1  SHALL be a one-cycle pulse at frame completion.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-014 Acceptance SHALL occur on a cycle with data_valid && ready; data_in SHALL be latched into the shift register and the FSM SHALL go IDLE->START.
REQ-015 ready SHALL equal (state == IDLE); data_valid while not ready SHALL be ignored, with no queuing.
REQ-016 tx SHALL drive 0 starting in the cycle after acceptance (latency 1).
REQ-017 Each of START, each data bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a clk_count counter that clears at every bit boundary.
REQ-018 Data SHALL be sent LSB first; a bit_count counter SHALL run 0..DATA_WIDTH-1, and DATA SHALL exit after bit DATA_WIDTH-1 completes.
REQ-019 STOP SHALL drive tx=1; at the end of STOP the FSM SHALL return to IDLE and done SHALL pulse for exactly that one transition cycle.
REQ-020 ready SHALL rise in the cycle after the last STOP cycle, and a byte accepted in that cycle SHALL start with no idle gap beyond the one IDLE cycle.
REQ-021 busy SHALL equal !ready.
REQ-022 A frame SHALL be 1+DATA_WIDTH+1 bits without the macro and 1+DATA_WIDTH+1+1 bits with it.
REQ-023 Counters SHALL never wrap within a bit; clk_count SHALL be reset to 0 on every state change.
REQ-024 data_in changing after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-025 On reset_n=0: state=IDLE, tx=1, ready=1, busy=0, done=0, all counters=0, shift register=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (asynchronously), with tx=1 and no done pulse.
REQ-027 After reset_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-028 UART_TX_PARITY_EN, when defined, SHALL insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles.
REQ-029 When UART_TX_PARITY_EN is undefined, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Verification
All scenarios use CLK_FREQ=1_600_000, BAUD_RATE=100_000, so CLKS_PER_BIT=16; DATA_WIDTH=8.
REQ-030 Send 0x55 -> tx low for cycles 1-16 after acceptance, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles, then done pulses at cycle 161 and ready=1 at 161.
REQ-031 Send 0xA5 then 0x3C back-to-back with data_valid held high -> second start bit begins at cycle 162, both frames decode correctly, and 2 done pulses occur.
REQ-032 Drive data_valid with 0xFF at cycle 40 of an active frame -> ignored; the current frame is unchanged and ready stays 0 until the frame ends.
REQ-033 Assert reset_n=0 at cycle 70 of a 0x00 frame -> tx=1 and ready=1 asynchronously, no done pulse; a following 0x81 transmits correctly.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> a parity bit of 1 occupies cycles 145-160 and done pulses at cycle 177; send 0x03 -> parity bit 0.
